// File: rtl/onchip_mem_master_pkg.sv
// Shared FSM state, command opcodes and bus constants for the on-chip memory init/self-test master.
package onchip_mem_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD_REQ,
      RD_WAIT,
      FIN
   } state_t;

   localparam logic       OP_FILL  = 1'b0;
   localparam logic       OP_CHECK = 1'b1;
   localparam logic [3:0] BE_ALL   = 4'hF;

endpackage

// File: rtl/onchip_mem_master_if.sv
// Avalon-MM bus between the init/self-test master and the on-chip RAM slave port.
interface onchip_mem_master_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] avm_address;
   logic [3:0]        avm_byteenable;
   logic              avm_chipselect;
   logic              avm_write;
   logic              avm_read;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;
   logic              avm_waitrequest;
   logic              avm_clken;

   modport master (
      output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read,
             avm_writedata, avm_clken,
      input  avm_readdata, avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read,
             avm_writedata, avm_clken,
      output avm_readdata, avm_waitrequest
   );
endinterface

// File: rtl/onchip_mem_master_lat.sv
// Read-latency down-counter: loads on read accept, strobes o_rd_valid on the wait cycle carrying readdata.
module onchip_mem_master_lat #(
   parameter int READ_LATENCY = 1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_start,
   input  logic i_wait,
   output logic o_rd_valid
);
   localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_cnt <= '0;
      else if (i_start)
         r_cnt <= CW'(READ_LATENCY - 1);
      else if (r_cnt != '0)
         r_cnt <= r_cnt - CW'(1);
   end

   assign o_rd_valid = i_wait && (r_cnt == '0);

endmodule

// File: rtl/onchip_mem_master.sv
// Memory fill / read-checksum engine; FILL N words = N+1 cycles, CHECK = N*(READ_LATENCY+1)+1, stretched by waitrequest.
// One outstanding read; optional per-word compare under ONCHIP_MEM_MASTER_COMPARE_EN.
module onchip_mem_master
   import onchip_mem_master_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int DEPTH        = 4093,
   parameter int READ_LATENCY = 1,
   parameter int CNT_W        = 13
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_cmd_start,
   input  logic                i_cmd_op,
   input  logic [ADDR_W-1:0]   i_cmd_base,
   input  logic [CNT_W-1:0]    i_cmd_count,
   input  logic [31:0]         i_cmd_seed,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_cmd_err,
   output logic [31:0]         o_checksum,
`ifdef ONCHIP_MEM_MASTER_COMPARE_EN
   output logic [CNT_W-1:0]    o_err_count,
   output logic [ADDR_W-1:0]   o_err_addr,
`endif
   onchip_mem_master_if.master avm
);
   state_t              r_state, w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [CNT_W-1:0]    r_remain;
   logic [31:0]         r_data;
   logic [31:0]         r_checksum;
   logic                r_zero;
   logic                r_err;
   logic                w_accept, w_range_bad, w_last, w_rd_accept, w_rd_valid;

   assign w_range_bad = (32'(i_cmd_base) + 32'(i_cmd_count)) > 32'(DEPTH);
   assign w_accept    = i_cmd_start && (r_state == IDLE);
   assign w_last      = (r_remain == CNT_W'(1));
   assign w_rd_accept = (r_state == RD_REQ) && !avm.avm_waitrequest;

   onchip_mem_master_lat #(.READ_LATENCY(READ_LATENCY)) u_lat (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_start    (w_rd_accept),
      .i_wait     (r_state == RD_WAIT),
      .o_rd_valid (w_rd_valid)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next              = r_state;
      o_busy              = 1'b0;
      o_done              = 1'b0;
      avm.avm_write       = 1'b0;
      avm.avm_read        = 1'b0;
      avm.avm_chipselect  = 1'b0;
      avm.avm_byteenable  = 4'h0;
      avm.avm_address     = '0;
      avm.avm_writedata   = '0;
      avm.avm_clken       = (r_state != IDLE) || i_cmd_start;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_range_bad) begin
               if (i_cmd_count == '0)
                  w_next = FIN;
               else
                  w_next = (i_cmd_op == OP_CHECK) ? RD_REQ : WRITE;
            end
         end
         WRITE: begin
            o_busy             = 1'b1;
            avm.avm_write      = 1'b1;
            avm.avm_chipselect = 1'b1;
            avm.avm_byteenable = BE_ALL;
            avm.avm_address    = r_addr;
            avm.avm_writedata  = r_data;
            if (!avm.avm_waitrequest && w_last)
               w_next = FIN;
         end
         RD_REQ: begin
            o_busy             = 1'b1;
            avm.avm_read       = 1'b1;
            avm.avm_chipselect = 1'b1;
            avm.avm_byteenable = BE_ALL;
            avm.avm_address    = r_addr;
            if (!avm.avm_waitrequest)
               w_next = RD_WAIT;
         end
         RD_WAIT: begin
            o_busy = 1'b1;
            if (w_rd_valid)
               w_next = w_last ? FIN : RD_REQ;
         end
         FIN: begin
            // A zero-length command spends one extra busy cycle here before done.
            if (r_zero) begin
               o_busy = 1'b1;
            end else begin
               o_done = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_addr     <= '0;
         r_remain   <= '0;
         r_data     <= '0;
         r_checksum <= '0;
         r_zero     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_accept && w_range_bad;
         if (r_state == FIN)
            r_zero <= 1'b0;
         if (w_accept && !w_range_bad) begin
            r_addr   <= i_cmd_base;
            r_remain <= i_cmd_count;
            r_data   <= i_cmd_seed;
            r_zero   <= (i_cmd_count == '0);
            if (i_cmd_op == OP_CHECK)
               r_checksum <= '0;
         end else if ((r_state == WRITE && !avm.avm_waitrequest) ||
                      (r_state == RD_WAIT && w_rd_valid)) begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_remain <= r_remain - CNT_W'(1);
            r_data   <= r_data + 32'd1;
            if (r_state == RD_WAIT)
               r_checksum <= r_checksum + avm.avm_readdata;
         end
      end
   end

   assign o_checksum = r_checksum;
   assign o_cmd_err  = r_err;

`ifdef ONCHIP_MEM_MASTER_COMPARE_EN
   logic [CNT_W-1:0]  r_err_count;
   logic [ADDR_W-1:0] r_err_addr;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_err_count <= '0;
         r_err_addr  <= '0;
      end else if (w_accept && !w_range_bad && (i_cmd_op == OP_CHECK)) begin
         r_err_count <= '0;
         r_err_addr  <= '0;
      end else if (r_state == RD_WAIT && w_rd_valid && (avm.avm_readdata != r_data)) begin
         if (r_err_count == '0)
            r_err_addr <= r_addr;
         if (r_err_count != '1)
            r_err_count <= r_err_count + CNT_W'(1);
      end
   end

   assign o_err_count = r_err_count;
   assign o_err_addr  = r_err_addr;
`endif

endmodule

// File: tb/tb_onchip_mem_master.sv
// Bench for onchip_mem_master: RAM slave with stall injection, reference memory image and checksum model.
module tb_onchip_mem_master;
   localparam int   DEPTH    = 4093;
   localparam logic OP_FILL  = 1'b0;
   localparam logic OP_CHECK = 1'b1;
   localparam int   LOGN     = 1024;

   logic        clk, rst;
   logic        cmd_start, cmd_op;
   logic [11:0] cmd_base;
   logic [12:0] cmd_count;
   logic [31:0] cmd_seed;
   logic        busy, done, cmd_err;
   logic [31:0] checksum;
`ifdef ONCHIP_MEM_MASTER_COMPARE_EN
   logic [12:0] err_count;
   logic [11:0] err_addr;
`endif

   onchip_mem_master_if #(.ADDR_W(12)) bus ();

   onchip_mem_master #(.ADDR_W(12), .DEPTH(DEPTH), .READ_LATENCY(1), .CNT_W(13)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_cmd_start (cmd_start),
      .i_cmd_op    (cmd_op),
      .i_cmd_base  (cmd_base),
      .i_cmd_count (cmd_count),
      .i_cmd_seed  (cmd_seed),
      .o_busy      (busy),
      .o_done      (done),
      .o_cmd_err   (cmd_err),
      .o_checksum  (checksum),
`ifdef ONCHIP_MEM_MASTER_COMPARE_EN
      .o_err_count (err_count),
      .o_err_addr  (err_addr),
`endif
      .avm         (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] mem     [0:4095];
   logic [31:0] ref_mem [0:4095];
   logic [31:0] exp_ck = 0;
   bit          mem_ready = 0;
   bit          bd_vld = 0;
   logic [11:0] bd_addr = 0;
   logic [31:0] bd_data = 0;
   int          wr_beats = 0, rd_beats = 0, cs_cycles = 0, stall_cycles = 0, rw_both = 0;
   logic [11:0] log_a  [0:LOGN-1];
   logic [31:0] log_d  [0:LOGN-1];
   logic [3:0]  log_be [0:LOGN-1];
   int          stall_at = -1, stall_len = 0, stall_cnt = 0;
   bit          rand_stall = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // RAM slave, single-cycle read latency
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
         mem_ready <= 1'b1;
      end else if (bd_vld) begin
         mem[bd_addr] <= bd_data;
      end else if (bus.avm_clken && bus.avm_chipselect && !bus.avm_waitrequest) begin
         if (bus.avm_write) mem[bus.avm_address] <= bus.avm_writedata;
         if (bus.avm_read)  bus.avm_readdata <= mem[bus.avm_address];
      end
   end

   always @(posedge clk) begin
      #1;
      if (bus.avm_write && wr_beats == stall_at && stall_cnt < stall_len) begin
         bus.avm_waitrequest = 1'b1;
         stall_cnt++;
      end else begin
         if (wr_beats != stall_at) stall_cnt = 0;
         if (rand_stall && bus.avm_chipselect)
            bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
         else
            bus.avm_waitrequest = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.avm_chipselect) cs_cycles <= cs_cycles + 1;
         if (bus.avm_chipselect && bus.avm_waitrequest) stall_cycles <= stall_cycles + 1;
         if (bus.avm_read && bus.avm_write) rw_both <= rw_both + 1;
         if (bus.avm_chipselect && bus.avm_write && !bus.avm_waitrequest) begin
            log_a[wr_beats % LOGN]  <= bus.avm_address;
            log_d[wr_beats % LOGN]  <= bus.avm_writedata;
            log_be[wr_beats % LOGN] <= bus.avm_byteenable;
            wr_beats <= wr_beats + 1;
         end
         if (bus.avm_chipselect && bus.avm_read && !bus.avm_waitrequest) rd_beats <= rd_beats + 1;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic op_i, input logic [11:0] b, input logic [12:0] n,
                        input logic [31:0] s, output int t0);
      @(posedge clk); #1;
      cmd_start = 1'b1; cmd_op = op_i; cmd_base = b; cmd_count = n; cmd_seed = s;
      t0 = cyc;
      @(posedge clk); #1;
      cmd_start = 1'b0;
   endtask

   task automatic wait_done(input int t0, input int limit, output int lat);
      lat = -1;
      for (int k = 0; k < limit; k++) begin
         if (done === 1'b1) begin
            lat = cyc - t0;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [31:0] ref_sum(input logic [11:0] b, input logic [12:0] n);
      logic [31:0] acc = 32'h0;
      for (int i = 0; i < int'(n); i++) acc += ref_mem[int'(b) + i];
      return acc;
   endfunction

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, cmd_err, bus.avm_chipselect, bus.avm_write, bus.avm_read,
           bus.avm_clken, bus.avm_byteenable} !== 11'h0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b done=%b err=%b cs=%b wr=%b rd=%b clken=%b be=%h, required all 0",
                  busy, done, cmd_err, bus.avm_chipselect, bus.avm_write, bus.avm_read,
                  bus.avm_clken, bus.avm_byteenable);
      end
      checks++;
      if ({checksum, bus.avm_address, bus.avm_writedata} !== 76'h0) begin
         errors++;
         $display("FAIL reset_data: checksum=%h addr=%h wdata=%h, required 0", checksum,
                  bus.avm_address, bus.avm_writedata);
      end
`ifdef ONCHIP_MEM_MASTER_COMPARE_EN
      checks++;
      if (err_count !== 13'h0 || err_addr !== 12'h0) begin
         errors++;
         $display("FAIL reset_cmp: err_count=%h err_addr=%h, required 0", err_count, err_addr);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_fill_basic();
      int t0, lat, w0;
      w0 = wr_beats;
      issue(OP_FILL, 12'h010, 13'd4, 32'h1000_0000, t0);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL fill_busy_rise: busy=%b, required 1", busy);
      end
      wait_done(t0, 200, lat);
      checks++;
      if (lat !== 5) begin
         errors++; $display("FAIL fill_latency: got %0d cycles, required 5", lat);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL fill_busy_at_done: busy=%b, required 0", busy);
      end
      checks++;
      if (wr_beats - w0 !== 4) begin
         errors++; $display("FAIL fill_beats: got %0d, required 4", wr_beats - w0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (log_a[(w0 + i) % LOGN] !== 12'(16 + i) || log_d[(w0 + i) % LOGN] !== 32'h1000_0000 + i ||
             log_be[(w0 + i) % LOGN] !== 4'hF) begin
            errors++;
            $display("FAIL fill_beat%0d: addr=%h data=%h be=%h, required addr=%h data=%h be=f", i,
                     log_a[(w0 + i) % LOGN], log_d[(w0 + i) % LOGN], log_be[(w0 + i) % LOGN],
                     12'(16 + i), 32'h1000_0000 + i);
         end
         ref_mem[16 + i] = 32'h1000_0000 + i;
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL fill_done_pulse: done=%b one cycle later, required 0", done);
      end
   endtask

   task automatic test_check_basic();
      int t0, lat;
      issue(OP_CHECK, 12'h010, 13'd4, 32'h0, t0);
      wait_done(t0, 200, lat);
      checks++;
      if (lat !== 9) begin
         errors++; $display("FAIL check_latency: got %0d cycles, required 9", lat);
      end
      exp_ck = 32'h4000_0006;
      checks++;
      if (checksum !== exp_ck) begin
         errors++; $display("FAIL check_sum: got %h, required %h", checksum, exp_ck);
      end
   endtask

   task automatic test_stall();
      int t0, lat, held, w0;
      logic [31:0] s;
      s = $urandom;
      w0 = wr_beats;
      stall_at = w0 + 1;
      stall_len = 3;
      issue(OP_FILL, 12'h020, 13'd4, s, t0);
      held = 0;
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.avm_chipselect && bus.avm_waitrequest) begin
            held++;
            checks++;
            if (bus.avm_address !== 12'h021 || bus.avm_writedata !== s + 1 || bus.avm_write !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold: addr=%h data=%h wr=%b, required addr=021 data=%h wr=1",
                        bus.avm_address, bus.avm_writedata, bus.avm_write, s + 1);
            end
         end
         if (done === 1'b1) begin
            lat = cyc - t0;
            break;
         end
      end
      stall_at = -1;
      checks++;
      if (held !== 3) begin
         errors++; $display("FAIL stall_cycles: got %0d, required 3", held);
      end
      checks++;
      if (lat !== 8) begin
         errors++; $display("FAIL stall_latency: got %0d cycles, required 8", lat);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (log_a[(w0 + i) % LOGN] !== 12'(32 + i) || log_d[(w0 + i) % LOGN] !== s + i) begin
            errors++;
            $display("FAIL stall_beat%0d: addr=%h data=%h, required addr=%h data=%h", i,
                     log_a[(w0 + i) % LOGN], log_d[(w0 + i) % LOGN], 12'(32 + i), s + i);
         end
         ref_mem[32 + i] = s + i;
      end
      checks++;
      if (checksum !== exp_ck) begin
         errors++; $display("FAIL fill_keeps_checksum: got %h, required %h", checksum, exp_ck);
      end
   endtask

   task automatic test_range();
      int t0, lat, cs0;
      logic [31:0] s;
      cs0 = cs_cycles;
      issue(OP_CHECK, 12'hFF0, 13'h010, 32'h0, t0);
      checks++;
      if (cmd_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL range_reject: cmd_err=%b busy=%b, required 1/0", cmd_err, busy);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cmd_err !== 1'b0 || cs_cycles !== cs0 || checksum !== exp_ck) begin
         errors++;
         $display("FAIL range_quiet: cmd_err=%b cs_cycles=%0d checksum=%h, required 0/%0d/%h",
                  cmd_err, cs_cycles, checksum, cs0, exp_ck);
      end
      s = $urandom;
      issue(OP_FILL, 12'hFF0, 13'd13, s, t0);
      checks++;
      if (cmd_err !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL range_edge_accept: cmd_err=%b busy=%b, required 0/1", cmd_err, busy);
      end
      wait_done(t0, 200, lat);
      checks++;
      if (lat !== 14) begin
         errors++; $display("FAIL range_edge_latency: got %0d, required 14", lat);
      end
      for (int i = 0; i < 13; i++) ref_mem[16'hFF0 + i] = s + i;
      cs0 = cs_cycles;
      issue(OP_CHECK, 12'h005, 13'd0, 32'h0, t0);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL zero_busy: busy=%b done=%b, required 1/0", busy, done);
      end
      wait_done(t0, 50, lat);
      checks++;
      if (lat !== 2) begin
         errors++; $display("FAIL zero_latency: got %0d, required 2", lat);
      end
      exp_ck = 32'h0;
      checks++;
      if (checksum !== exp_ck || cs_cycles !== cs0) begin
         errors++;
         $display("FAIL zero_result: checksum=%h cs_cycles=%0d, required 0/%0d", checksum, cs_cycles, cs0);
      end
   endtask

   task automatic test_busy_ignore();
      int t0, lat, errs, w0;
      logic [31:0] s;
      s = $urandom;
      w0 = wr_beats;
      issue(OP_FILL, 12'h040, 13'd6, s, t0);
      errs = 0;
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         if (cmd_err === 1'b1) errs++;
         if (done === 1'b1) begin
            lat = cyc - t0;
            break;
         end
         if (cyc - t0 == 3) begin
            cmd_start = 1'b1; cmd_op = OP_CHECK; cmd_base = 12'hFFF; cmd_count = 13'd100;
         end else begin
            cmd_start = 1'b0;
         end
         @(posedge clk); #1;
      end
      cmd_start = 1'b0;
      checks++;
      if (lat !== 7 || errs !== 0) begin
         errors++; $display("FAIL busy_ignore: latency=%0d cmd_err_cycles=%0d, required 7/0", lat, errs);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (log_a[(w0 + i) % LOGN] !== 12'(64 + i) || log_d[(w0 + i) % LOGN] !== s + i) begin
            errors++;
            $display("FAIL busy_ignore_beat%0d: addr=%h data=%h, required addr=%h data=%h", i,
                     log_a[(w0 + i) % LOGN], log_d[(w0 + i) % LOGN], 12'(64 + i), s + i);
         end
         ref_mem[64 + i] = s + i;
      end
   endtask

   task automatic test_reset_mid();
      int t0, lat, rd0, seen;
      bit found;
      logic [31:0] s;
      rd0 = rd_beats;
      issue(OP_CHECK, 12'h010, 13'd4, 32'h0, t0);
      found = 0;
      for (int k = 0; k < 50; k++) begin
         if (bus.avm_read === 1'b1 && rd_beats == rd0 + 1) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL rstmid_reach: second read request seen=%0d, required 1", found);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, cmd_err, bus.avm_chipselect, bus.avm_read, bus.avm_write, bus.avm_clken} !== 7'h0 ||
          checksum !== 32'h0 || bus.avm_address !== 12'h0) begin
         errors++;
         $display("FAIL rstmid_outputs: busy=%b done=%b cs=%b rd=%b clken=%b checksum=%h addr=%h, required 0",
                  busy, done, bus.avm_chipselect, bus.avm_read, bus.avm_clken, checksum, bus.avm_address);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL rstmid_no_done: done pulses=%0d, required 0", seen);
      end
      exp_ck = 32'h0;
      s = $urandom;
      issue(OP_FILL, 12'h200, 13'd5, s, t0);
      wait_done(t0, 100, lat);
      checks++;
      if (lat !== 6) begin
         errors++; $display("FAIL rstmid_refill_latency: got %0d, required 6", lat);
      end
      for (int i = 0; i < 5; i++) ref_mem[16'h200 + i] = s + i;
      issue(OP_CHECK, 12'h200, 13'd5, 32'h0, t0);
      wait_done(t0, 100, lat);
      exp_ck = ref_sum(12'h200, 13'd5);
      checks++;
      if (lat !== 11 || checksum !== exp_ck) begin
         errors++;
         $display("FAIL rstmid_recheck: latency=%0d checksum=%h, required 11/%h", lat, checksum, exp_ck);
      end
   endtask

   task automatic test_random();
      int t0, lat, w0, st0, cs0, maxc, exp_lat;
      bit bad;
      logic op;
      logic [11:0] b;
      logic [12:0] n;
      logic [31:0] s;
      rand_stall = 1;
      for (int it = 0; it < 30; it++) begin
         op = 1'($urandom_range(0, 1));
         b = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4060, 4092)) : 12'($urandom_range(0, 4092));
         maxc = DEPTH - int'(b);
         bad = ($urandom_range(0, 5) == 0);
         if (bad) n = 13'(maxc + 1 + int'($urandom_range(0, 7)));
         else     n = 13'($urandom_range(0, (maxc < 40) ? maxc : 40));
         s = $urandom;
         w0 = wr_beats; st0 = stall_cycles; cs0 = cs_cycles;
         issue(op, b, n, s, t0);
         if (bad) begin
            checks++;
            if (cmd_err !== 1'b1 || busy !== 1'b0) begin
               errors++;
               $display("FAIL rand_reject it=%0d base=%h cnt=%0d: cmd_err=%b busy=%b, required 1/0",
                        it, b, n, cmd_err, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (cs_cycles !== cs0 || checksum !== exp_ck) begin
               errors++;
               $display("FAIL rand_reject_quiet it=%0d: cs_cycles=%0d checksum=%h, required %0d/%h",
                        it, cs_cycles, checksum, cs0, exp_ck);
            end
         end else begin
            wait_done(t0, 4000, lat);
            if (n == 13'd0)          exp_lat = 2;
            else if (op == OP_CHECK) exp_lat = 2 * int'(n) + 1;
            else                     exp_lat = int'(n) + 1;
            exp_lat += stall_cycles - st0;
            checks++;
            if (lat !== exp_lat) begin
               errors++;
               $display("FAIL rand_latency it=%0d op=%b base=%h cnt=%0d: got %0d, required %0d",
                        it, op, b, n, lat, exp_lat);
            end
            if (op == OP_FILL) begin
               checks++;
               if (wr_beats - w0 !== int'(n)) begin
                  errors++;
                  $display("FAIL rand_fill_beats it=%0d: got %0d, required %0d", it, wr_beats - w0, n);
               end
               for (int i = 0; i < int'(n); i++) begin
                  checks++;
                  if (log_a[(w0 + i) % LOGN] !== 12'(int'(b) + i) || log_d[(w0 + i) % LOGN] !== s + i) begin
                     errors++;
                     $display("FAIL rand_fill_beat it=%0d i=%0d: addr=%h data=%h, required addr=%h data=%h",
                              it, i, log_a[(w0 + i) % LOGN], log_d[(w0 + i) % LOGN], 12'(int'(b) + i), s + i);
                  end
                  ref_mem[int'(b) + i] = s + i;
               end
            end else begin
               exp_ck = ref_sum(b, n);
            end
            checks++;
            if (checksum !== exp_ck) begin
               errors++;
               $display("FAIL rand_checksum it=%0d op=%b base=%h cnt=%0d: got %h, required %h",
                        it, op, b, n, checksum, exp_ck);
            end
         end
      end
      rand_stall = 0;
   endtask

`ifdef ONCHIP_MEM_MASTER_COMPARE_EN
   task automatic test_compare();
      int t0, lat;
      issue(OP_FILL, 12'h300, 13'd6, 32'h0, t0);
      wait_done(t0, 100, lat);
      for (int i = 0; i < 6; i++) ref_mem[16'h300 + i] = 32'(i);
      @(posedge clk); #1;
      bd_addr = 12'h303; bd_data = 32'hDEAD_BEEF; bd_vld = 1'b1;
      @(posedge clk); #1;
      bd_vld = 1'b0;
      ref_mem[16'h303] = 32'hDEAD_BEEF;
      issue(OP_CHECK, 12'h300, 13'd6, 32'h0, t0);
      wait_done(t0, 100, lat);
      exp_ck = ref_sum(12'h300, 13'd6);
      checks++;
      if (err_count !== 13'd1 || err_addr !== 12'h303) begin
         errors++;
         $display("FAIL compare_err: err_count=%0d err_addr=%h, required 1/303", err_count, err_addr);
      end
      checks++;
      if (checksum !== exp_ck) begin
         errors++; $display("FAIL compare_checksum: got %h, required %h", checksum, exp_ck);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      cmd_start = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_count = '0; cmd_seed = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
      test_reset();
      test_fill_basic();
      test_check_basic();
      test_stall();
      test_range();
      test_busy_ignore();
      test_reset_mid();
      test_random();
`ifdef ONCHIP_MEM_MASTER_COMPARE_EN
      test_compare();
`endif
      checks++;
      if (rw_both !== 0) begin
         errors++; $display("FAIL rw_exclusive: read and write together in %0d cycles, required 0", rw_both);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/onchip_mem_master.md
Name: onchip_mem_master

Overview:
- Avalon-MM initiator (master) driving the 32-bit single-port on-chip memory slave (12-bit word address, 4093 words, byteenable, clken, fixed read latency).
- On command, it either fills a block of words with an incrementing pattern or reads a block back and accumulates a 32-bit checksum.
- Sits beside the soft processor as a memory init/self-test engine. Its master port connects to the memory's s1/s2 slave through the interconnect.

Parameters:
- ADDR_W, 12, word-address width of the target memory.
- DEPTH, 4093, number of valid words; highest legal address is DEPTH-1.
- READ_LATENCY, 1, clocks from read-accept to valid readdata (1 to 4).
- CNT_W, 13, width of the word-count command field.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_start  in  1  one-cycle command strobe; accepted only when busy=0
- cmd_op  in  1  0 = FILL (write), 1 = CHECK (read and sum)
- cmd_base  in  ADDR_W  first word address
- cmd_count  in  CNT_W  number of words
- cmd_seed  in  32  FILL pattern seed
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  one-cycle pulse: command rejected for range
- checksum  out  32  CHECK result, held until next accepted command
- avm_address  out  ADDR_W  Avalon address
- avm_byteenable  out  4  always 4'hF during accesses
- avm_chipselect  out  1  asserted with read or write
- avm_write  out  1  write request
- avm_read  out  1  read request
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall; tie 0 for on-chip RAM
- avm_clken  out  1  clock enable to the slave; 1 except in IDLE with no request

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All outputs 0: busy, done, cmd_err, checksum, avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read, avm_writedata, avm_clken.
- Command acceptance:
  - When cmd_start=1 and state=IDLE, the command is sampled.
  - If cmd_base + cmd_count > DEPTH, the command is rejected: cmd_err pulses the next cycle, state stays IDLE, checksum is unchanged.
  - cmd_start while busy=1 is ignored. No error is raised.
  - cmd_count = 0 with a legal base: busy is held high for one cycle, then done pulses; checksum = 0 for CHECK; no bus access occurs.
- States:
  - IDLE: waiting for a command.
  - WRITE: avm_write = avm_chipselect = 1, avm_address = base+i, avm_writedata = seed+i (32-bit wraparound). A beat completes on any cycle where waitrequest=0; i then increments. After the last beat, go to FIN.
  - RD_REQ: avm_read = avm_chipselect = 1, avm_address = base+i. When waitrequest=0, go to RD_WAIT.
  - RD_WAIT: count READ_LATENCY-1 cycles. On the cycle readdata is valid, checksum += readdata (mod 2^32), then i++. Go to RD_REQ, or to FIN after the last word. Reads are non-pipelined: one outstanding read.
  - FIN: done = 1 for one cycle, busy = 0, go to IDLE.
- Timing:
  - busy rises the cycle after an accepted cmd_start.
  - With waitrequest=0, FILL of N words takes N+1 cycles from start to the done pulse.
  - With waitrequest=0, CHECK of N words takes N*(READ_LATENCY+1)+1 cycles from start to the done pulse.
- Bus signal rules:
  - Address, writedata and control are held stable while waitrequest=1.
  - read and write are never asserted together.
- checksum is cleared when a CHECK command is accepted. It is not cleared by a FILL.
- The address never exceeds DEPTH-1, guaranteed by the range check, so no wrap-around occurs.
- Reset asserted mid-operation aborts immediately; no done pulse is produced.

Optional Feature:
- Macro: ONCHIP_MEM_MASTER_COMPARE_EN.
- Defined:
  - CHECK also compares each readdata against seed+i.
  - Adds outputs err_count (CNT_W bits, saturating) and err_addr (ADDR_W bits, the first mismatching address).
  - Both outputs are cleared on CHECK accept and reset to 0.
- Undefined: no compare logic and no extra ports.

Decomposition:
- Package onchip_mem_master_pkg holds:
  - state enum (IDLE, WRITE, RD_REQ, RD_WAIT, FIN);
  - OP_FILL / OP_CHECK constants;
  - BE_ALL = 4'hF.
- One sub-module, onchip_mem_master_lat, a READ_LATENCY down-counter producing the rd_valid strobe.

Test Plan:
- FILL base=0x010, count=4, seed=0x1000_0000 -> writes 0x10000000..0x10000003 to addresses 0x010..0x013; done on cycle 5; byteenable = 4'hF.
- CHECK of the same block -> checksum = 0x4000_0006; with READ_LATENCY=1, done 9 cycles after start.
- waitrequest held high 3 cycles on the 2nd write -> address and writedata stable for those cycles; done delayed by exactly 3 cycles.
- base=0xFF0, count=0x010 (sum 4096 > 4093) -> cmd_err pulse, no avm_chipselect, busy stays 0; count=0 -> done pulse, checksum = 0.
- Reset asserted during CHECK word 2 -> all outputs 0 immediately, no done; a new FILL afterwards completes normally.
- (COMPARE_EN) FILL seed=0, corrupt word 3 via backdoor, CHECK -> err_count = 1, err_addr = base+3.
